// File: rtl/vm_pkg.sv
// Shared vending-machine constants: coin denominations, tube indices and
// change-dispenser state encodings.
package vm_pkg;

  localparam logic [7:0] DENOM_HI  = 8'd10;
  localparam logic [7:0] DENOM_MID = 8'd5;
  localparam logic [7:0] DENOM_LO  = 8'd1;

  localparam int TUBE_HI  = 32'sd2;
  localparam int TUBE_MID = 32'sd1;
  localparam int TUBE_LO  = 32'sd0;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SELECT    = 3'd1;
  localparam logic [2:0] ST_EJECT     = 3'd2;
  localparam logic [2:0] ST_WAIT_SEEN = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_FAULT     = 3'd6;

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter that stops at zero; expired is decoded from the
// registered count so it carries no combinational path from load.
module dispense_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_r;

  // count register: load wins, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout through the 10/5/1 coin tubes, one coin at a time,
// each coin confirmed by the exit sensor before the next is selected.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYC    = 4,
  parameter int GAP_CYC      = 2,
  parameter int SEEN_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_dispense_en,
  input  logic [AMT_W-1:0] change_amount,
  input  logic [2:0]       tube_empty,
  input  logic             coin_seen,
  output logic [2:0]       eject,
  output logic             change_dispense_done,
  output logic             busy,
  output logic             fault,
  output logic [AMT_W-1:0] remaining,
  output logic [7:0]       coins_out
);

  localparam int TMR_MAX = (SEEN_TIMEOUT > PULSE_CYC)
                         ? ((SEEN_TIMEOUT > GAP_CYC) ? SEEN_TIMEOUT : GAP_CYC)
                         : ((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC);
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  logic [2:0]       state_r, state_s;
  logic [AMT_W-1:0] remaining_r, remaining_s;
  logic [AMT_W-1:0] denom_r, denom_s, pick_denom_s;
  logic [2:0]       sel_r, sel_s, pick_sel_s;
  logic             pick_ok_s;
  logic [7:0]       coins_r, coins_s;
  logic             fault_r, fault_s;
  logic             seen_flag_r, seen_flag_s;
  logic             tmr_load_s;
  logic [TMR_W-1:0] tmr_val_s;
  logic             tmr_expired_s;

  dispense_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .expired  (tmr_expired_s)
  );

  // greedy denomination pick: largest coin that fits and whose tube has stock
  always_comb begin
    pick_sel_s   = 3'b000;
    pick_denom_s = '0;
    pick_ok_s    = 1'b0;
    if (remaining_r >= AMT_W'(DENOM_HI) && !tube_empty[TUBE_HI]) begin
      pick_sel_s   = 3'b100;
      pick_denom_s = AMT_W'(DENOM_HI);
      pick_ok_s    = 1'b1;
    end else if (remaining_r >= AMT_W'(DENOM_MID) && !tube_empty[TUBE_MID]) begin
      pick_sel_s   = 3'b010;
      pick_denom_s = AMT_W'(DENOM_MID);
      pick_ok_s    = 1'b1;
    end else if (remaining_r >= AMT_W'(DENOM_LO) && !tube_empty[TUBE_LO]) begin
      pick_sel_s   = 3'b001;
      pick_denom_s = AMT_W'(DENOM_LO);
      pick_ok_s    = 1'b1;
    end else begin
      pick_sel_s   = 3'b000;
      pick_denom_s = '0;
      pick_ok_s    = 1'b0;
    end
  end

  // next-state and datapath update logic
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    denom_s     = denom_r;
    sel_s       = sel_r;
    coins_s     = coins_r;
    fault_s     = fault_r;
    seen_flag_s = seen_flag_r;
    tmr_load_s  = 1'b0;
    tmr_val_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (change_dispense_en) begin
          remaining_s = change_amount;
          coins_s     = 8'd0;
          fault_s     = 1'b0;
          state_s     = ST_SELECT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        seen_flag_s = 1'b0;
        if (remaining_r == '0) begin
          state_s = ST_DONE;
        end else if (pick_ok_s) begin
          sel_s      = pick_sel_s;
          denom_s    = pick_denom_s;
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(PULSE_CYC - 1);
          state_s    = ST_EJECT;
        end else begin
          fault_s = 1'b1;
          state_s = ST_FAULT;
        end
      end
      ST_EJECT: begin
        // a fast sensor may fire before the pulse ends; remember it
        if (coin_seen) begin
          seen_flag_s = 1'b1;
        end else begin
          seen_flag_s = seen_flag_r;
        end
        if (tmr_expired_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(SEEN_TIMEOUT - 1);
          state_s    = ST_WAIT_SEEN;
        end else begin
          state_s = ST_EJECT;
        end
      end
      ST_WAIT_SEEN: begin
        if (coin_seen || seen_flag_r) begin
          remaining_s = remaining_r - denom_r;
          coins_s     = (coins_r == 8'hFF) ? coins_r : coins_r + 8'd1;
          seen_flag_s = 1'b0;
          tmr_load_s  = 1'b1;
          tmr_val_s   = TMR_W'(GAP_CYC - 1);
          state_s     = ST_GAP;
        end else if (tmr_expired_s) begin
          fault_s = 1'b1;
          state_s = ST_FAULT;
        end else begin
          state_s = ST_WAIT_SEEN;
        end
      end
      ST_GAP: begin
        if (tmr_expired_s) begin
          state_s = ST_SELECT;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      ST_FAULT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      denom_r     <= '0;
      sel_r       <= 3'b000;
      coins_r     <= 8'd0;
      fault_r     <= 1'b0;
      seen_flag_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      denom_r     <= denom_s;
      sel_r       <= sel_s;
      coins_r     <= coins_s;
      fault_r     <= fault_s;
      seen_flag_r <= seen_flag_s;
    end
  end

  assign eject                = (state_r == ST_EJECT) ? sel_r : 3'b000;
  assign change_dispense_done = (state_r == ST_DONE) || (state_r == ST_FAULT);
  assign busy                 = (state_r != ST_IDLE);
  assign fault                = fault_r;
  assign remaining            = remaining_r;
  assign coins_out            = coins_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues the
// expected eject codes and completion record, checked as the DUT produces them.
module tb_change_dispenser;

  localparam int PULSE = 4;

  typedef struct packed {
    logic       flt;
    logic [7:0] rem;
    logic [7:0] coins;
  } res_t;

  logic       clk;
  logic       rst;
  logic       change_dispense_en;
  logic [7:0] change_amount;
  logic [2:0] tube_empty;
  logic       coin_seen;
  logic [2:0] eject;
  logic       change_dispense_done;
  logic       busy;
  logic       fault;
  logic [7:0] remaining;
  logic [7:0] coins_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_ej_q[$];
  res_t       exp_res_q[$];

  logic [2:0] prev_eject = 3'b000;
  int         pulse_len  = 0;
  int         resp_cnt   = 0;
  int         busy_cyc   = 0;
  bit         respond    = 1'b1;
  bit         done_seen  = 1'b0;

  change_dispenser dut (
    .clk                  (clk),
    .rst                  (rst),
    .change_dispense_en   (change_dispense_en),
    .change_amount        (change_amount),
    .tube_empty           (tube_empty),
    .coin_seen            (coin_seen),
    .eject                (eject),
    .change_dispense_done (change_dispense_done),
    .busy                 (busy),
    .fault                (fault),
    .remaining            (remaining),
    .coins_out            (coins_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // greedy payout model; a missing sensor pulse ends the payout after its first coin
  task automatic expect_payout(input logic [7:0] amt, input logic [2:0] te, input bit resp);
    logic [7:0] rem;
    logic [7:0] coins;
    logic [7:0] d;
    logic [2:0] code;
    logic       flt;
    rem = amt; coins = 8'd0; flt = 1'b0;
    while (rem != 8'd0) begin
      if (rem >= 8'd10 && !te[2]) begin code = 3'b100; d = 8'd10; end
      else if (rem >= 8'd5 && !te[1]) begin code = 3'b010; d = 8'd5; end
      else if (!te[0]) begin code = 3'b001; d = 8'd1; end
      else begin flt = 1'b1; break; end
      exp_ej_q.push_back(code);
      if (!resp) begin flt = 1'b1; break; end
      rem = rem - d;
      coins = coins + 8'd1;
    end
    exp_res_q.push_back('{flt, rem, coins});
  endtask

  // one clock: sample at negedge, check eject/done events, play the exit sensor
  task automatic tick();
    res_t r;
    @(negedge clk);
    if (rst) begin
      prev_eject = 3'b000;
      pulse_len  = 0;
      resp_cnt   = 0;
      coin_seen  = 1'b0;
    end else begin
      if (coin_seen) coin_seen = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) coin_seen = 1'b1;
      end
      if (busy) busy_cyc++;
      if (eject != 3'b000) begin
        if (eject != prev_eject) begin
          check("eject_onehot", $countones(eject), 1);
          if (exp_ej_q.size() == 0) check("eject_unexpected", {29'd0, eject}, 0);
          else check("eject_code", {29'd0, eject}, {29'd0, exp_ej_q.pop_front()});
          pulse_len = 1;
        end else begin
          pulse_len++;
        end
      end else if (prev_eject != 3'b000) begin
        check("pulse_len", pulse_len, PULSE);
        if (respond) resp_cnt = 2;
      end
      if (change_dispense_done) begin
        done_seen = 1'b1;
        if (exp_res_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          r = exp_res_q.pop_front();
          check("fault", {31'd0, fault}, {31'd0, r.flt});
          check("remaining", {24'd0, remaining}, {24'd0, r.rem});
          check("coins_out", {24'd0, coins_out}, {24'd0, r.coins});
        end
      end
      prev_eject = eject;
    end
  endtask

  task automatic run_payout(input logic [7:0] amt, input logic [2:0] te, input bit resp,
                            input bit hold_en, output int lat);
    expect_payout(amt, te, resp);
    respond            = resp;
    tube_empty         = te;
    change_amount      = amt;
    change_dispense_en = 1'b1;
    busy_cyc           = 0;
    done_seen          = 1'b0;
    lat                = 0;
    for (int k = 1; k <= 300 && !done_seen; k++) begin
      tick();
      lat = k;
      if (!hold_en || done_seen) change_dispense_en = 1'b0;
    end
    if (!done_seen) check("done_timeout", 0, 1);
    change_dispense_en = 1'b0;
    check("eject_leftover", exp_ej_q.size(), 0);
    tick();
    check("done_width", {31'd0, change_dispense_done}, 0);
    check("busy_after", {31'd0, busy}, 0);
  endtask

  initial begin
    int lat;
    int waited;
    rst = 1'b1; change_dispense_en = 1'b0; change_amount = 8'd0;
    tube_empty = 3'b000; coin_seen = 1'b0;
    repeat (3) tick();
    check("rst_eject", {29'd0, eject}, 0);
    check("rst_done", {31'd0, change_dispense_done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_fault", {31'd0, fault}, 0);
    check("rst_remaining", {24'd0, remaining}, 0);
    check("rst_coins", {24'd0, coins_out}, 0);
    rst = 1'b0;
    tick();

    run_payout(8'd17, 3'b000, 1'b1, 1'b0, lat);

    // en held through the payout must not start a second one
    run_payout(8'd12, 3'b100, 1'b1, 1'b1, lat);
    repeat (4) tick();
    check("no_requeue_busy", {31'd0, busy}, 0);

    run_payout(8'd0, 3'b000, 1'b1, 1'b0, lat);
    check("zero_latency", lat, 2);
    check("zero_busy_cycles", busy_cyc, 2);

    run_payout(8'd7, 3'b000, 1'b0, 1'b0, lat);
    check("timeout_latency", lat, 1 + PULSE + 64 + 1);
    repeat (3) tick();
    check("fault_sticky", {31'd0, fault}, 1);
    run_payout(8'd1, 3'b000, 1'b1, 1'b0, lat);
    check("fault_cleared", {31'd0, fault}, 0);

    run_payout(8'd3, 3'b101, 1'b1, 1'b0, lat);
    check("nostock_latency", lat, 2);

    // reset in the second cycle of the first eject pulse
    expect_payout(8'd17, 3'b000, 1'b1);
    respond = 1'b1; tube_empty = 3'b000; change_amount = 8'd17;
    change_dispense_en = 1'b1;
    waited = 0;
    while (eject == 3'b000 && waited < 20) begin
      tick();
      waited++;
    end
    check("pre_reset_eject", {29'd0, eject}, 3'b100);
    tick();
    rst = 1'b1;
    exp_ej_q.delete();
    exp_res_q.delete();
    tick();
    check("mid_rst_eject", {29'd0, eject}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, change_dispense_done}, 0);
    check("mid_rst_remaining", {24'd0, remaining}, 0);
    check("mid_rst_coins", {24'd0, coins_out}, 0);
    rst = 1'b0;
    change_dispense_en = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Responder end of the controller's change-dispense handshake. The controller pulses change_dispense_en with the change amount. This block pays it out greedily through three coin-tube ejectors (10/5/1 units), confirming each coin with the exit sensor. It then returns a one-cycle change_dispense_done and sits between the FSM controller / change calculator and the coin-hopper hardware.

Parameters:
AMT_W, 8, width of change amount and remaining counter (units)
PULSE_CYC, 4, eject solenoid pulse width in clk cycles (>=1)
GAP_CYC, 2, idle cycles between coins (>=1)
SEEN_TIMEOUT, 64, max cycles waiting for coin_seen after pulse ends before fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
change_dispense_en  in  1  start request; sampled only in IDLE
change_amount  in  AMT_W  amount to pay; latched when start accepted
tube_empty  in  3  [2]=10-unit, [1]=5-unit, [0]=1-unit tube empty
coin_seen  in  1  exit-sensor pulse, one per coin (single-cycle, synchronous)
eject  out  3  one-hot solenoid drive, same bit mapping as tube_empty
change_dispense_done  out  1  one-cycle completion pulse (success or fault)
busy  out  1  high in every state except IDLE
fault  out  1  sticky: payout aborted
remaining  out  AMT_W  amount still owed
coins_out  out  8  coins confirmed in current/last payout (saturates at 255)

Behaviour:
- Reset (rst high at clk edge): state=IDLE, eject=0, done=0, busy=0, fault=0, remaining=0, coins_out=0. Reset mid-payout aborts immediately; eject drops the cycle after the reset edge.
- All outputs are registered or decoded from the registered state only; no combinational input-to-output paths.
- IDLE: if change_dispense_en, latch remaining=change_amount, clear coins_out and fault, go to SELECT. change_dispense_en outside IDLE is ignored, with no queueing.
- SELECT (1 cycle): tube_empty is sampled here only.
  - If remaining==0, go to DONE.
  - Else pick the largest d in {10,5,1} with d<=remaining and its tube not empty, then go to EJECT.
  - If no such d exists, go to FAULT.
- EJECT: eject[sel]=1 for exactly PULSE_CYC cycles, then WAIT_SEEN. A coin_seen arriving during EJECT is captured in a flag.
- WAIT_SEEN: on coin_seen (or captured flag), remaining -= d, coins_out += 1, go to GAP.
  - Counter counts cycles in WAIT_SEEN. If SEEN_TIMEOUT cycles elapse without a coin, go to FAULT with remaining unchanged.
  - Extra coin_seen pulses beyond one per eject are ignored. coin_seen in IDLE/SELECT/GAP/DONE is ignored.
- GAP: eject=0 for GAP_CYC cycles, then SELECT.
- DONE: change_dispense_done=1 for one cycle, then IDLE.
- FAULT: fault=1 (sticky until rst or next accepted start), change_dispense_done=1 for one cycle, then IDLE. remaining holds the unpaid amount for the controller and display.
- Zero amount: en accepted at edge N gives SELECT at N+1, DONE at N+2 (done high that cycle), and no eject.
- Arithmetic: the subtraction never underflows, because d<=remaining is checked in SELECT. coins_out saturates.
- eject is at most one-hot at all times and never high outside EJECT.

Decomposition:
- Shared package vm_pkg holds:
  - Denomination constants DENOM_HI=10, DENOM_MID=5, DENOM_LO=1.
  - Tube index constants.
  - Dispenser state enumeration: IDLE, SELECT, EJECT, WAIT_SEEN, GAP, DONE, FAULT.
- One sub-module, dispense_timer: a loadable down-counter with an expired flag. It is reused for PULSE_CYC, GAP_CYC and SEEN_TIMEOUT.
- Denomination selection stays inline as a priority mux.

Test Plan:
- Amount 17, all tubes full, coin_seen returned 2 cycles after each pulse -> eject order 100,010,001,001; each pulse 4 cycles; coins_out=4; remaining=0; single done pulse; fault=0.
- Amount 12, tube_empty=100 -> eject order 010,010,001,001; done; coins_out=4.
- Amount 0 -> done high exactly 2 cycles after the accepted en; eject never asserted; busy high 2 cycles.
- Amount 7, coin_seen never returned -> after the 4-cycle pulse plus 64 cycles: fault=1, done pulse, remaining=7, coins_out=0. A following en with amount 1 clears fault.
- Amount 3, tube_empty=101 -> FAULT straight from SELECT, no eject, remaining=3, done pulse.
- rst asserted during the second cycle of an eject pulse -> eject=0 the next cycle, state IDLE, all outputs at reset values; en held high during busy ignored (no second payout).
